// File: rtl/vector_addsub_pipe_if.sv
// Stream bundle for vector_addsub_pipe: operand beat in, result beat out,
// each side with its own valid/ready pair.
interface vector_addsub_pipe_if #(
    parameter int W = 8,
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a [N-1:0];
    logic [W-1:0] b [N-1:0];
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y [N-1:0];
    logic [N-1:0] ovf;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, ovf
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, ovf
    );
endinterface

// File: rtl/vector_addsub_pipe.sv
// N-lane add/subtract with wrap or saturate, per-lane overflow flags and a
// LATENCY-deep global-stall valid/ready pipeline.
module vector_addsub_pipe #(
    parameter int W       = 8,
    parameter int N       = 4,
    parameter int LATENCY = 2,
    parameter int SIGNED  = 0
) (
    input  logic                clock,
    input  logic                reset,
    vector_addsub_pipe_if.slave bus
);

    // On overflow a signed result clips toward the sign of a (which equals
    // b's sign for add); unsigned clips to all-ones on carry, zero on borrow.
    function automatic logic [W-1:0] sat_value(input logic sub, input logic a_msb);
        if (SIGNED != 0)
            return a_msb ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            return sub ? {W{1'b0}} : {W{1'b1}};
    endfunction

    // Returns {overflow, result}.
    function automatic logic [W:0] lane_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op);
        logic [W:0]        ext;
        logic signed [W:0] sx;
        logic              ov;
        if (SIGNED != 0) begin
            if (op[0]) sx = $signed({a[W-1], a}) - $signed({b[W-1], b});
            else       sx = $signed({a[W-1], a}) + $signed({b[W-1], b});
            ext = sx;
            ov  = sx[W] ^ sx[W-1];
        end else begin
            if (op[0]) ext = {1'b0, a} - {1'b0, b};
            else       ext = {1'b0, a} + {1'b0, b};
            sx  = '0;
            ov  = ext[W];
        end
        return {ov, (op[1] && ov) ? sat_value(op[0], a[W-1]) : ext[W-1:0]};
    endfunction

    logic [W-1:0] y_c   [N-1:0];
    logic [N-1:0] ovf_c;

    logic [LATENCY-1:0] vld_p;
    logic [W-1:0]       y_p   [LATENCY-1:0][N-1:0];
    logic [N-1:0]       ovf_p [LATENCY-1:0];
    logic               advance;

    always_comb begin
        ovf_c = '0;
        for (int i = 0; i < N; i++) y_c[i] = '0;
        for (int i = 0; i < N; i++) begin
            {ovf_c[i], y_c[i]} = lane_calc(bus.a[i], bus.b[i], bus.op);
        end
    end

    assign advance      = bus.out_ready | ~vld_p[LATENCY-1];
    assign bus.in_ready = advance;

    // Stage 1 captures lane math; later stages are plain delay.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p <= '0;
        end else if (advance) begin
            vld_p[0] <= bus.in_valid;
            for (int s = 1; s < LATENCY; s++) vld_p[s] <= vld_p[s-1];
        end
    end

    always_ff @(posedge clock) begin
        if (advance) begin
            if (bus.in_valid) begin
                for (int i = 0; i < N; i++) y_p[0][i] <= y_c[i];
                ovf_p[0] <= ovf_c;
            end
            for (int s = 1; s < LATENCY; s++) begin
                for (int i = 0; i < N; i++) y_p[s][i] <= y_p[s-1][i];
                ovf_p[s] <= ovf_p[s-1];
            end
        end
    end

    // Data regs are not reset, so outputs are masked by the final valid bit.
    assign bus.out_valid = vld_p[LATENCY-1];
    assign bus.ovf       = vld_p[LATENCY-1] ? ovf_p[LATENCY-1] : '0;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.y[i] = vld_p[LATENCY-1] ? y_p[LATENCY-1][i] : '0;
        end
    end

endmodule

// File: doc/vector_addsub_pipe.md
# vector_addsub_pipe

Parametrised N-lane, W-bit vector add/subtract unit with selectable wrap or saturating arithmetic, per-lane overflow flags and a configurable-depth valid/ready pipeline. Successor to the fixed single-register lane-wise adder: it adds subtraction, signed/unsigned saturation, overflow reporting, pipeline depth and backpressure. It sits between an upstream vector producer and a downstream consumer in the datapath evaluation designs.

## Interface
- W, 8: lane width in bits (≥2)
- N, 4: lane count (≥1)
- LATENCY, 2: pipeline register stages (≥1)
- SIGNED, 0: 1 = two's-complement lanes, 0 = unsigned

- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  unit accepts beat this cycle
- op  in  2  bit0: 1 = subtract (a−b), 0 = add; bit1: 1 = saturate, 0 = wrap
- a  in  [W-1:0] x N  unpacked operand array a[N-1:0]
- b  in  [W-1:0] x N  unpacked operand array b[N-1:0]
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts beat
- y  out  [W-1:0] x N  lane results y[N-1:0]
- ovf  out  N  ovf[i] = lane i overflowed/underflowed (flag valid whatever op[1] is)

## Operation
- Lane math is computed combinationally from a, b, op at the input and captured into stage 1. Stages 2..LATENCY are pure delay registers carrying {valid, y, ovf}.
- Unsigned add: full W+1-bit sum. ovf = carry out. Saturate → 2^W−1.
- Unsigned sub: ovf = borrow (a<b). Saturate → 0.
- Signed add: ovf when operands share a sign and the result sign differs. Saturate → 2^(W−1)−1 if operands are non-negative, else −2^(W−1).
- Signed sub: ovf when operand signs differ and the result sign differs from a. Saturate → max if a is non-negative, else min.
- Wrap mode (op[1]=0): y = low W bits of the result. ovf is still reported.
- Lanes are fully independent. All lanes in a beat share op.
- Global-stall pipeline: advance = out_ready | ~out_valid. in_ready = advance.
- On advance, every stage shifts by one. Stage 1 loads valid = in_valid, plus data when in_valid. A bubble (in_valid=0) shifts in valid=0.
- No advance: all stages hold. y and ovf stay stable while out_valid=1 and out_ready=0.
- Data registers of invalid stages are don't-care internally. The y/ovf outputs must still be zero after reset until the first beat arrives.

## Timing
- Reset asserted: all valid bits, y, and ovf are 0 immediately (async). in_ready = 1 (since out_valid = 0).
- Reset deasserted: first acceptance is possible on the next rising edge.
- A beat accepted at edge k presents out_valid=1 after edge k+LATENCY−1, provided no stalls occur. It completes at the first edge ≥ that point with out_ready=1.
- Throughput is one beat per cycle with out_ready held high. No bubbles are inserted.
- Stall:
  - in_ready falls combinationally in the same cycle that out_valid=1 and out_ready=0.
  - in_valid, op, a, b presented while in_ready=0 are ignored. The upstream holds them.
- Simultaneous out_ready and in_valid while the pipeline is full: the output beat retires and the input beat is accepted on the same edge.
- Reset mid-operation: all in-flight beats are discarded. No partial beat emerges after release.
- Combinational paths: out_ready → in_ready only. There is no path from a, b, or op to any output.

## Test plan
- W=8, N=4, LATENCY=2, SIGNED=0. Beat a={200,10,255,0}, b={100,5,1,0}, op=00 at edge 0 → after edge 1: out_valid=1, y={44,15,0,0}, ovf=4'b0101 (lanes 0 and 2 set).
- Same operands with op=10 → y={255,15,255,0}, ovf=4'b0101. Next, a={5,9,0,7}, b={9,5,1,7}, op=11 → y={0,4,0,0}, ovf=4'b0101 (lanes 0 and 2 set).
- SIGNED=1, op=10: a={127,−128,−1,50}, b={1,−1,−1,−60} → y={127,−128,−2,−10}, ovf=4'b0011. Then op=11 with a={−128,127,0,0}, b={1,−1,−128,0} → y={−128,127,127,0}, ovf=4'b0111.
- Back-to-back stream of 16 incrementing beats with out_ready=1 → 16 outputs on 16 consecutive cycles, in order, no gaps.
- Stream with out_ready held low 5 cycles mid-stream:
  - in_ready drops the same cycle the output stalls.
  - y is frozen throughout the stall.
  - No beat is lost or duplicated.
  - Order is preserved after out_ready returns.
- Assert reset asynchronously (between edges) with 2 beats in flight → out_valid, y, ovf read 0 before the next edge. After release, no stale beat appears, and a fresh beat completes with latency 2.
